red_pitaya_fads_mc: RTL and testbench
=====================================

# red_pitaya_fads_mc

Multi-channel, parametrised fluorescence-activated droplet sorter for the RedPitaya ADC clock domain. Channel 0 detects droplets. Every enabled channel tracks its peak intensity during the droplet, and the droplet is classified against per-channel intensity windows and a width window. A delayed sort pulse drives the ASG trigger, and one record per droplet is pushed into a readable event FIFO on the system bus.

## Interface
- NCH, 2: number of ADC channels (1..4)
- DW, 14: ADC sample / threshold width, signed
- CW, 32: width/delay/counter width
- LOGD, 4: log2 of event FIFO depth
- adc_clk_i  in  1  ADC clock; sole clock
- adc_rstn_i  in  1  reset, asynchronous, active-low
- adc_i  in  NCH*DW  signed samples; channel k at [k*DW +: DW]
- sort_trig  out  1  sort pulse to ASG
- debug  out  8  one-hot state (bit = state index)
- sys_addr/sys_wdata/sys_sel/sys_wen/sys_ren  in  32/32/4/1/1  system bus
- sys_rdata  out  32  read data
- sys_err  out  1  always 0
- sys_ack  out  1  acknowledge

## Operation
- Register map (sys_addr[19:0]); writes use sys_wdata LSBs:
  - 0x000 ctrl: [0] acq_en, [1] sort_en, [2] clear (self-clearing pulse; reads 0)
  - 0x004 min_thr (DW, signed), 0x008 min_w, 0x00C low_w, 0x010 high_w
  - 0x014 sort_delay, 0x018 sort_dur, 0x01C ch_mask[NCH-1:0]
  - 0x040+8k low_thr[k], 0x044+8k high_thr[k] (signed)
  - 0x100 positive, 0x104 negative, 0x108 dropped (RO)
  - 0x10C status (RO): [3:0] state, [15:8] fifo count, [16] full, [17] empty
  - 0x200 fifo data (RO; a read pops)
- Signed registers read back sign-extended. Unmapped reads return 0 with ack.
- Defaults: acq_en=1, sort_en=1, min_thr=15, low_thr=16, high_thr=0x1FFF, min_w=1, low_w=1, high_w=all-ones, sort_delay=31250, sort_dur=125000, ch_mask=all-ones.
- States (one-hot debug):
  - IDLE(0): go to WAIT when acq_en=1.
  - WAIT(1): when ch0 >= min_thr, set width=1, max[k]=sample[k] for all k, and go to ACQ.
  - ACQ(2): width+1 (saturating at all-ones); max[k]=max(max[k],sample[k]), signed. When ch0 < min_thr, go to EVAL.
  - EVAL(3), one cycle:
    - pos = (width in [low_w,high_w)) AND (width >= min_w) AND, for each k with mask bit set, max[k] in [low_thr[k],high_thr[k]).
    - pos increments positive; otherwise negative increments.
    - Push record {bit31 pos, bit30 sort_issued, bits29:24 0, bits23:0 width saturated to 24 bits}.
    - sort_issued = pos AND sort_en. If set, go to DELAY; otherwise go to IDLE.
  - DELAY(4): wait sort_delay cycles, then go to SORT. 0 means go straight to SORT.
  - SORT(5): sort_trig=1 for sort_dur cycles, then go to IDLE. sort_dur=0 produces no pulse.
- FIFO: depth 2^LOGD, 32-bit.
  - Push when full drops the record and increments dropped, unless a pop occurs in the same cycle (then no drop).
  - Pop when empty returns 0 and state is unchanged.
- Clear, in any state:
  - Next state IDLE, sort_trig=0.
  - positive/negative/dropped zeroed, FIFO flushed.
  - Configuration kept.
- Clearing acq_en only gates IDLE->WAIT; it does not abort a droplet in progress.
- Counters wrap at 2^CW.

## Timing
- Async reset sets state IDLE and all registers to defaults; outputs are sort_trig=0, debug=0x01, sys_ack=0, sys_err=0, sys_rdata=0.
- Detection latency: sample >= min_thr at cycle t -> ACQ at t+1.
- EVAL occurs 1 cycle after the falling sample. The first sort_trig rises at EVAL+1+sort_delay.
- A droplet of N samples above threshold records width=N.
- Bus: sys_ack and sys_rdata are registered, 1 cycle after sys_wen|sys_ren. FIFO pop takes effect on the same edge.
- Clear write lands at edge t; the state machine is in IDLE at t+1.

## Test plan
- Reset defaults: reads of 0x004/0x014/0x018 return 15/31250/125000; debug=0x01; sort_trig=0.
- Single-channel positive: NCH=2, ch_mask=1, low_w=5, high_w=20, ch0 pulse of 500 for 10 cycles -> positive=1, FIFO record 0xC000000A, sort_trig high exactly sort_dur cycles starting sort_delay+1 cycles after EVAL.
- Two-channel veto: ch_mask=3, ch1 peak 8000 >= high_thr[1]=1000 -> negative=1, record 0x0000000A, no pulse.
- FIFO overflow: LOGD=2, 6 droplets, no reads -> count=4, full=1, dropped=2; 4 pops return in order, then a 5th pop returns 0.
- Clear during SORT: write ctrl=0x7 mid-pulse -> sort_trig=0 and debug=0x01 next cycle, counters 0, empty=1.
- Edges: sort_delay=0, sort_dur=0 -> positive counted, no sort_trig pulse. A 1-cycle droplet with min_w=2 is negative.

Source files
------------

// File: rtl/red_pitaya_fads_mc.sv
// -----------------------------------------------------------------------------
// red_pitaya_fads_mc
// Multi-channel fluorescence-activated droplet sorter in the ADC clock domain.
// Channel 0 detects droplets; every channel tracks its peak while a droplet is
// present. Each droplet is classified against per-channel intensity windows
// and a width window. A positive droplet (with sorting enabled) fires a
// delayed sort pulse. One record per droplet goes into a bus-readable FIFO.
//
// Ports
//   adc_clk_i   ADC clock (sole clock)
//   adc_rstn_i  asynchronous active-low reset
//   adc_i       NCH signed samples, channel k at [k*DW +: DW]
//   sort_trig   sort pulse towards the ASG trigger
//   debug       one-hot state (bit index = state index)
//   sys_*       system bus slave (registered ack/rdata, err tied low)
// -----------------------------------------------------------------------------
module red_pitaya_fads_mc #(
  parameter int NCH  = 2,
  parameter int DW   = 14,
  parameter int CW   = 32,
  parameter int LOGD = 4
) (
  input  logic              adc_clk_i,
  input  logic              adc_rstn_i,
  input  logic [NCH*DW-1:0] adc_i,
  output logic              sort_trig,
  output logic [7:0]        debug,
  input  logic [31:0]       sys_addr,
  input  logic [31:0]       sys_wdata,
  input  logic [3:0]        sys_sel,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [31:0]       sys_rdata,
  output logic              sys_err,
  output logic              sys_ack
);

  localparam int DEPTH = 1 << LOGD;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_ACQ   = 3'd2,
    S_EVAL  = 3'd3,
    S_DELAY = 3'd4,
    S_SORT  = 3'd5
  } state_t;

  // Width counter saturates instead of wrapping so very long droplets stay long.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic [23:0] sat24(input logic [CW-1:0] v);
    logic [63:0] w;
    w = 64'(v);
    return (w > 64'hFF_FFFF) ? 24'hFF_FFFF : w[23:0];
  endfunction

  function automatic logic [31:0] sext(input logic signed [DW-1:0] v);
    return {{(32-DW){v[DW-1]}}, v};
  endfunction

  function automatic logic [19:0] thr_addr(input int k, input logic hi);
    return 20'(32'h40 + 8 * k + (hi ? 4 : 0));
  endfunction

  logic [19:0] addr;
  logic        unused_bits;
  assign addr        = sys_addr[19:0];
  assign unused_bits = ^{sys_sel, sys_addr[31:20]};
  assign sys_err     = 1'b0;

  // Samples
  logic signed [DW-1:0] smp [NCH];
  always_comb begin
    for (int k = 0; k < NCH; k++) smp[k] = $signed(adc_i[k*DW +: DW]);
  end

  // Configuration registers
  logic                 acq_en, sort_en, clr_p0;
  logic signed [DW-1:0] min_thr;
  logic [CW-1:0]        min_w, low_w, high_w, sort_delay, sort_dur;
  logic [NCH-1:0]       ch_mask;
  logic signed [DW-1:0] low_thr  [NCH];
  logic signed [DW-1:0] high_thr [NCH];

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      acq_en     <= 1'b1;
      sort_en    <= 1'b1;
      clr_p0     <= 1'b0;
      min_thr    <= DW'(15);
      min_w      <= CW'(1);
      low_w      <= CW'(1);
      high_w     <= '1;
      sort_delay <= CW'(31250);
      sort_dur   <= CW'(125000);
      ch_mask    <= '1;
      for (int k = 0; k < NCH; k++) begin
        low_thr[k]  <= DW'(16);
        high_thr[k] <= DW'(8191);
      end
    end else begin
      clr_p0 <= 1'b0;
      if (sys_wen) begin
        case (addr)
          20'h000: begin
            acq_en  <= sys_wdata[0];
            sort_en <= sys_wdata[1];
            clr_p0  <= sys_wdata[2];
          end
          20'h004: min_thr    <= $signed(sys_wdata[DW-1:0]);
          20'h008: min_w      <= sys_wdata[CW-1:0];
          20'h00C: low_w      <= sys_wdata[CW-1:0];
          20'h010: high_w     <= sys_wdata[CW-1:0];
          20'h014: sort_delay <= sys_wdata[CW-1:0];
          20'h018: sort_dur   <= sys_wdata[CW-1:0];
          20'h01C: ch_mask    <= sys_wdata[NCH-1:0];
          default: begin
            for (int k = 0; k < NCH; k++) begin
              if (addr == thr_addr(k, 1'b0)) low_thr[k]  <= $signed(sys_wdata[DW-1:0]);
              if (addr == thr_addr(k, 1'b1)) high_thr[k] <= $signed(sys_wdata[DW-1:0]);
            end
          end
        endcase
      end
    end
  end

  // State machine
  state_t        state, state_nx;
  logic [CW-1:0] tmr, tmr_nx;
  logic          above, pos, sort_issued;
  logic [CW-1:0] width;
  logic signed [DW-1:0] max_v [NCH];

  assign above       = (smp[0] >= min_thr);
  assign sort_issued = pos && sort_en;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    case (state)
      S_IDLE: if (acq_en) state_nx = S_WAIT;
      S_WAIT: if (above) state_nx = S_ACQ;
      S_ACQ:  if (!above) state_nx = S_EVAL;
      S_EVAL: begin
        tmr_nx = '0;
        if (!sort_issued)          state_nx = S_IDLE;
        else if (sort_delay == '0) state_nx = S_SORT;
        else                       state_nx = S_DELAY;
      end
      S_DELAY: begin
        if (tmr + CW'(1) >= sort_delay) begin
          state_nx = S_SORT;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + CW'(1);
        end
      end
      S_SORT: begin
        // With sort_dur = 0 the state is still visited for one cycle, but
        // sort_trig is gated off so no pulse appears.
        if (tmr + CW'(1) >= sort_dur) begin
          state_nx = S_IDLE;
          tmr_nx   = '0;
        end else begin
          tmr_nx = tmr + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (clr_p0) begin
      state_nx = S_IDLE;
      tmr_nx   = '0;
    end
  end

  always_comb begin
    debug        = '0;
    debug[state] = 1'b1;
  end

  assign sort_trig = (state == S_SORT) && (sort_dur != '0);

  // Droplet measurement; only samples still above threshold contribute, so
  // N samples above threshold yield width N.
  always_ff @(posedge adc_clk_i) begin
    if (state == S_WAIT && above) begin
      width <= CW'(1);
      for (int k = 0; k < NCH; k++) max_v[k] <= smp[k];
    end else if (state == S_ACQ && above) begin
      width <= sat_inc(width);
      for (int k = 0; k < NCH; k++)
        if (smp[k] > max_v[k]) max_v[k] <= smp[k];
    end
  end

  always_comb begin
    pos = (width >= low_w) && (width < high_w) && (width >= min_w);
    for (int k = 0; k < NCH; k++)
      if (ch_mask[k] && ((max_v[k] < low_thr[k]) || (max_v[k] >= high_thr[k])))
        pos = 1'b0;
  end

  // Event FIFO and counters
  logic [31:0]     fifo_mem [DEPTH];
  logic [LOGD-1:0] wr_ptr, rd_ptr;
  logic [LOGD:0]   fifo_cnt;
  logic            fifo_full, fifo_empty, rd_fifo, pop, push_req, push, drop;
  logic [31:0]     record;
  logic [CW-1:0]   positive, negative, dropped;

  assign fifo_full  = fifo_cnt[LOGD];
  assign fifo_empty = (fifo_cnt == '0);
  assign rd_fifo    = sys_ren && (addr == 20'h200);
  assign pop        = rd_fifo && !fifo_empty;
  assign push_req   = (state == S_EVAL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && !push;
  assign record     = {pos, sort_issued, 6'b0, sat24(width)};

  always_ff @(posedge adc_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= record;
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      positive <= '0;
      negative <= '0;
      dropped  <= '0;
    end else if (clr_p0) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      positive <= '0;
      negative <= '0;
      dropped  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOGD'(1);
      if (pop)  rd_ptr <= rd_ptr + LOGD'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (LOGD+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (LOGD+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req) begin
        if (pos) positive <= positive + CW'(1);
        else     negative <= negative + CW'(1);
      end
      if (drop) dropped <= dropped + CW'(1);
    end
  end

  // Bus read path, registered one cycle after the request
  logic [31:0] rdata_nx;
  always_comb begin
    rdata_nx = '0;
    case (addr)
      20'h000: rdata_nx = {30'b0, sort_en, acq_en};
      20'h004: rdata_nx = sext(min_thr);
      20'h008: rdata_nx = 32'(min_w);
      20'h00C: rdata_nx = 32'(low_w);
      20'h010: rdata_nx = 32'(high_w);
      20'h014: rdata_nx = 32'(sort_delay);
      20'h018: rdata_nx = 32'(sort_dur);
      20'h01C: rdata_nx = 32'(ch_mask);
      20'h100: rdata_nx = 32'(positive);
      20'h104: rdata_nx = 32'(negative);
      20'h108: rdata_nx = 32'(dropped);
      20'h10C: rdata_nx = {14'b0, fifo_empty, fifo_full, 8'(fifo_cnt), 4'b0, 1'b0, state};
      20'h200: rdata_nx = fifo_empty ? 32'b0 : fifo_mem[rd_ptr];
      default: begin
        for (int k = 0; k < NCH; k++) begin
          if (addr == thr_addr(k, 1'b0)) rdata_nx = sext(low_thr[k]);
          if (addr == thr_addr(k, 1'b1)) rdata_nx = sext(high_thr[k]);
        end
      end
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rdata_nx : 32'b0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_fads_mc.sv
module tb_red_pitaya_fads_mc;
  localparam int NCH = 2, DW = 14, CW = 32, LOGD = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NCH*DW-1:0] adc = '0;
  logic              sort_trig;
  logic [7:0]        debug;
  logic [31:0]       sys_addr = '0, sys_wdata = '0;
  logic [3:0]        sys_sel = 4'hF;
  logic              sys_wen = 1'b0, sys_ren = 1'b0;
  logic [31:0]       sys_rdata;
  logic              sys_err, sys_ack;

  int n_tests = 0, n_fail = 0;

  // droplet samples and mirrored configuration for the reference model
  int      d0 [64];
  int      d1 [64];
  int      m_min_w = 1, m_low_w = 1, m_mask = 3;
  longint  m_high_w = 64'hFFFF_FFFF;
  int      m_lo [2];
  int      m_hi [2];
  bit      m_sort_en = 1'b1;
  int      m_dur = 125000;
  int      m_pos = 0, m_neg = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  red_pitaya_fads_mc #(.NCH(NCH), .DW(DW), .CW(CW), .LOGD(LOGD)) dut (
    .adc_clk_i (clk),
    .adc_rstn_i(rstn),
    .adc_i     (adc),
    .sort_trig (sort_trig),
    .debug     (debug),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  // ---------------- bus and stimulus helpers ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(negedge clk); sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk); sys_addr = a; sys_ren = 1'b1;
    @(negedge clk); sys_ren = 1'b0; d = sys_rdata; ack = sys_ack;
  endtask

  task automatic cfg(input logic [31:0] a, input int v);
    bus_write(a, 32'(v));
    case (a)
      32'h008: m_min_w  = v;
      32'h00C: m_low_w  = v;
      32'h010: m_high_w = longint'(unsigned'(v));
      32'h018: m_dur    = v;
      32'h01C: m_mask   = v;
      32'h040: m_lo[0]  = v;
      32'h044: m_hi[0]  = v;
      32'h048: m_lo[1]  = v;
      32'h04C: m_hi[1]  = v;
      default: ;
    endcase
  endtask

  task automatic do_clear(input logic [31:0] ctrl);
    bus_write(32'h0, ctrl | 32'h4);
    m_sort_en = ctrl[1];
    m_pos = 0; m_neg = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // drives n samples, then one below-threshold sample; EVAL is seen at the next negedge
  task automatic send_droplet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); adc = {DW'(d1[i]), DW'(d0[i])};
    end
    @(negedge clk); adc = '0;
  endtask

  task automatic wait_done(output int tc, output bit to);
    bit done;
    done = 1'b0; tc = 0; to = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sort_trig) tc++;
      if (debug == 8'h01) begin done = 1'b1; to = 1'b0; end
    end
  endtask

  // Reference model: classification straight from the droplet samples
  function automatic logic [31:0] model_rec(input int n);
    int mx0, mx1;
    bit ok;
    mx0 = d0[0]; mx1 = d1[0];
    for (int i = 1; i < n; i++) begin
      if (d0[i] > mx0) mx0 = d0[i];
      if (d1[i] > mx1) mx1 = d1[i];
    end
    ok = (n >= m_low_w) && (longint'(n) < m_high_w) && (n >= m_min_w);
    if (m_mask[0] && !(mx0 >= m_lo[0] && mx0 < m_hi[0])) ok = 1'b0;
    if (m_mask[1] && !(mx1 >= m_lo[1] && mx1 < m_hi[1])) ok = 1'b0;
    return {ok, ok && m_sort_en, 6'b0, 24'(n)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic a;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (debug !== 8'h01) begin n_fail++; $display("FAIL reset_debug got %0h want 01", debug); end
    n_tests++; if (sort_trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig got %0b want 0", sort_trig); end
    n_tests++; if (sys_ack !== 1'b0 || sys_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got %0b%0b want 00", sys_ack, sys_err); end
    n_tests++; if (sys_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %0h want 0", sys_rdata); end
    rstn = 1'b1;
    m_lo[0] = 16; m_lo[1] = 16; m_hi[0] = 8191; m_hi[1] = 8191;
    bus_read(32'h004, d, a);
    n_tests++; if (d !== 32'd15) begin n_fail++; $display("FAIL min_thr_default got %0d want 15", d); end
    n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL read_ack got %0b want 1", a); end
    bus_read(32'h014, d, a);
    n_tests++; if (d !== 32'd31250) begin n_fail++; $display("FAIL sort_delay_default got %0d want 31250", d); end
    bus_read(32'h018, d, a);
    n_tests++; if (d !== 32'd125000) begin n_fail++; $display("FAIL sort_dur_default got %0d want 125000", d); end
    bus_read(32'h044, d, a);
    n_tests++; if (d !== 32'h1FFF) begin n_fail++; $display("FAIL high_thr_default got %0h want 1fff", d); end
    bus_read(32'h010, d, a);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL high_w_default got %0h want ffffffff", d); end
    bus_read(32'h10C, d, a);
    n_tests++; if (d !== 32'h0002_0001) begin n_fail++; $display("FAIL status_default got %0h want 20001", d); end
    bus_read(32'h300, d, a);
    n_tests++; if (d !== 32'h0 || a !== 1'b1) begin n_fail++; $display("FAIL unmapped got %0h ack %0b want 0 ack 1", d, a); end
    bus_write(32'h004, 32'h3FFF);
    bus_read(32'h004, d, a);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL min_thr_sext got %0h want ffffffff", d); end
    bus_write(32'h004, 32'd15);
  endtask

  task automatic test_single_pos();
    logic [31:0] d; logic a; int first, cnt;
    do_clear(32'h3);
    cfg(32'h01C, 1); cfg(32'h00C, 5); cfg(32'h010, 20);
    cfg(32'h014, 7); cfg(32'h018, 5);
    for (int i = 0; i < 10; i++) begin d0[i] = 500; d1[i] = 0; end
    send_droplet(10);
    @(negedge clk);
    n_tests++; if (debug !== 8'h08) begin n_fail++; $display("FAIL pos_eval_state got %0h want 08", debug); end
    first = -1; cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (sort_trig) begin cnt++; if (first < 0) first = c; end
    end
    n_tests++; if (first !== 8) begin n_fail++; $display("FAIL pos_trig_start got %0d want 8", first); end
    n_tests++; if (cnt !== 5) begin n_fail++; $display("FAIL pos_trig_len got %0d want 5", cnt); end
    bus_read(32'h100, d, a);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL pos_count got %0d want 1", d); end
    bus_read(32'h200, d, a);
    n_tests++; if (d !== 32'hC000_000A) begin n_fail++; $display("FAIL pos_record got %0h want c000000a", d); end
  endtask

  task automatic test_veto();
    logic [31:0] d; logic a; int tc; bit to;
    do_clear(32'h3);
    cfg(32'h01C, 3); cfg(32'h04C, 1000);
    for (int i = 0; i < 10; i++) begin d0[i] = 500; d1[i] = i * 100; end
    d1[5] = 8000;
    send_droplet(10);
    wait_done(tc, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL veto_timeout got %0b want 0", to); end
    n_tests++; if (tc !== 0) begin n_fail++; $display("FAIL veto_pulse got %0d want 0", tc); end
    bus_read(32'h104, d, a);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL veto_neg got %0d want 1", d); end
    bus_read(32'h200, d, a);
    n_tests++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL veto_record got %0h want 0000000a", d); end
    cfg(32'h04C, 8191);
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic a; int tc; bit to;
    do_clear(32'h1);
    cfg(32'h01C, 1); cfg(32'h00C, 1); cfg(32'h010, 20);
    for (int w = 1; w <= 6; w++) begin
      for (int i = 0; i < w; i++) begin d0[i] = 100; d1[i] = 0; end
      send_droplet(w);
      wait_done(tc, to);
      n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL ovf_timeout%0d got %0b want 0", w, to); end
      repeat (2) @(negedge clk);
    end
    bus_read(32'h10C, d, a);
    n_tests++; if (d[15:8] !== 8'd4 || d[16] !== 1'b1) begin n_fail++; $display("FAIL ovf_status got cnt %0d full %0b want 4 1", d[15:8], d[16]); end
    bus_read(32'h108, d, a);
    n_tests++; if (d !== 32'd2) begin n_fail++; $display("FAIL ovf_dropped got %0d want 2", d); end
    for (int i = 1; i <= 5; i++) begin
      bus_read(32'h200, d, a);
      n_tests++;
      if (d !== ((i <= 4) ? (32'h8000_0000 | 32'(i)) : 32'h0)) begin
        n_fail++; $display("FAIL ovf_pop%0d got %0h want %0h", i, d, (i <= 4) ? (32'h8000_0000 | 32'(i)) : 32'h0);
      end
    end
    bus_read(32'h10C, d, a);
    n_tests++; if (d[17] !== 1'b1 || d[15:8] !== 8'd0) begin n_fail++; $display("FAIL ovf_empty got %0h want empty", d); end
  endtask

  task automatic test_clear_sort();
    logic [31:0] d; logic a; bit seen;
    do_clear(32'h3);
    cfg(32'h01C, 1); cfg(32'h00C, 1); cfg(32'h010, 20);
    cfg(32'h014, 2); cfg(32'h018, 50);
    for (int i = 0; i < 10; i++) begin d0[i] = 500; d1[i] = 0; end
    send_droplet(10);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); if (sort_trig) seen = 1'b1; end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL clr_pulse_seen got %0b want 1", seen); end
    repeat (3) @(negedge clk);
    bus_write(32'h0, 32'h7);
    @(negedge clk);
    n_tests++; if (sort_trig !== 1'b0) begin n_fail++; $display("FAIL clr_trig got %0b want 0", sort_trig); end
    n_tests++; if (debug !== 8'h01) begin n_fail++; $display("FAIL clr_debug got %0h want 01", debug); end
    m_pos = 0; m_neg = 0; exp_q.delete();
    bus_read(32'h100, d, a);
    n_tests++; if (d !== 32'd0) begin n_fail++; $display("FAIL clr_pos got %0d want 0", d); end
    bus_read(32'h10C, d, a);
    n_tests++; if (d[17] !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %0b want 1", d[17]); end
  endtask

  task automatic test_edges();
    logic [31:0] d; logic a; int tc, first, cnt; bit to;
    do_clear(32'h3);
    cfg(32'h01C, 1); cfg(32'h00C, 1); cfg(32'h010, 20); cfg(32'h008, 1);
    cfg(32'h014, 0); cfg(32'h018, 0);
    for (int i = 0; i < 10; i++) begin d0[i] = 500; d1[i] = 0; end
    send_droplet(10);
    wait_done(tc, to);
    repeat (5) @(negedge clk) if (sort_trig) tc++;
    n_tests++; if (to !== 1'b0 || tc !== 0) begin n_fail++; $display("FAIL edge_nopulse got %0d to %0b want 0 0", tc, to); end
    bus_read(32'h100, d, a);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL edge_pos got %0d want 1", d); end
    bus_read(32'h200, d, a);
    n_tests++; if (d !== 32'hC000_000A) begin n_fail++; $display("FAIL edge_rec got %0h want c000000a", d); end
    cfg(32'h018, 3);
    send_droplet(10);
    @(negedge clk);
    first = -1; cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (sort_trig) begin cnt++; if (first < 0) first = c; end
    end
    n_tests++; if (first !== 1 || cnt !== 3) begin n_fail++; $display("FAIL edge_d0 got start %0d len %0d want 1 3", first, cnt); end
    bus_read(32'h200, d, a);
    cfg(32'h008, 2);
    send_droplet(1);
    wait_done(tc, to);
    bus_read(32'h104, d, a);
    n_tests++; if (d !== 32'd1) begin n_fail++; $display("FAIL edge_minw_neg got %0d want 1", d); end
    bus_read(32'h200, d, a);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL edge_minw_rec got %0h want 1", d); end
    cfg(32'h008, 1);
  endtask

  task automatic test_random();
    logic [31:0] d, er; logic a; int tc, n, lo, et; bit to;
    do_clear(32'h3);
    for (int it = 0; it < 12; it++) begin
      m_sort_en = 1'(($urandom & 1));
      bus_write(32'h0, {30'b0, m_sort_en, 1'b1});
      cfg(32'h01C, int'($urandom_range(3, 0)));
      for (int k = 0; k < 2; k++) begin
        lo = int'($urandom_range(4000, 0)) - 2000;
        cfg(32'h040 + 32'(8 * k), lo);
        cfg(32'h044 + 32'(8 * k), lo + int'($urandom_range(32'(8191 - lo), 0)));
      end
      cfg(32'h008, int'($urandom_range(4, 1)));
      cfg(32'h00C, int'($urandom_range(6, 1)));
      cfg(32'h010, int'($urandom_range(14, 4)));
      cfg(32'h014, int'($urandom_range(4, 0)));
      cfg(32'h018, int'($urandom_range(4, 0)));
      n = int'($urandom_range(12, 1));
      for (int i = 0; i < n; i++) begin
        d0[i] = int'($urandom_range(4000, 15));
        d1[i] = int'($urandom_range(16383, 0)) - 8192;
      end
      er = model_rec(n);
      if (er[31]) m_pos++; else m_neg++;
      exp_q.push_back(er);
      et = er[30] ? m_dur : 0;
      send_droplet(n);
      wait_done(tc, to);
      n_tests++; if (to !== 1'b0 || tc !== et) begin n_fail++; $display("FAIL rnd%0d_pulse got %0d to %0b want %0d", it, tc, to, et); end
      bus_read(32'h100, d, a);
      n_tests++; if (d !== 32'(m_pos)) begin n_fail++; $display("FAIL rnd%0d_pos got %0d want %0d", it, d, m_pos); end
      bus_read(32'h104, d, a);
      n_tests++; if (d !== 32'(m_neg)) begin n_fail++; $display("FAIL rnd%0d_neg got %0d want %0d", it, d, m_neg); end
      bus_read(32'h200, d, a);
      er = exp_q.pop_front();
      n_tests++; if (d !== er) begin n_fail++; $display("FAIL rnd%0d_rec got %0h want %0h", it, d, er); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_veto();
    test_overflow();
    test_clear_sort();
    test_edges();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
